// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the memory stage and the data memory.
// Committed stores are queued in a DEPTH-entry circular FIFO and drained to the
// memory write port whenever an unstalled load is not using that port.
// Loads look up the queue by word address. Store-to-load forwarding is built
// only when STORE_FWD_EN is defined. Without it, any address match with a
// queued store stalls the load until the matching stores have drained.
module store_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReqValid,
    input  logic                  iReqStore,
    input  logic [DATA_WIDTH-1:0] iAddress,
    input  logic [3:0]            iByteMask,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    output logic                  oStall,
    output logic                  oFwdValid,
    output logic [DATA_WIDTH-1:0] oFwdData,
    output logic                  oMemWriteEn,
    output logic [DATA_WIDTH-1:0] oMemAddress,
    output logic [DATA_WIDTH-1:0] oMemData,
    output logic [3:0]            oMemByteMask,
    input  logic                  iMemReady,
    output logic                  oEmpty
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WA_W   = DATA_WIDTH - 2;
    localparam int unsigned LANE_W = DATA_WIDTH / 4;

    // Queue storage and pointers
    logic [WA_W-1:0]       addr_q [DEPTH];
    logic [WA_W-1:0]       addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [3:0]            mask_q [DEPTH];
    logic [3:0]            mask_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // Request decode and control
    logic [WA_W-1:0]       req_waddr;
    logic                  is_load;
    logic                  is_store;
    logic                  empty;
    logic                  full;
    logic                  match_any;
    logic                  load_stall;
    logic                  stall;
    logic                  mem_we;
    logic                  enq;
    logic                  deq;
    logic                  fwd_valid;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [PTR_W-1:0]      idx;
    logic                  unused_addr_lsb;

`ifdef STORE_FWD_EN
    logic [3:0]            covered;
    logic [DATA_WIDTH-1:0] merged;
`endif

    assign req_waddr       = iAddress[DATA_WIDTH-1:2];
    // The byte offset is already folded into iByteMask, so the address LSBs carry no information here.
    assign unused_addr_lsb = ^iAddress[1:0];

    // Associative lookup: walk entries oldest to youngest so the youngest store wins each byte
    always_comb begin
        match_any = 1'b0;
        idx       = '0;
`ifdef STORE_FWD_EN
        covered   = '0;
        merged    = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == req_waddr)) begin
                match_any = 1'b1;
`ifdef STORE_FWD_EN
                covered = covered | mask_q[idx];
                for (int unsigned b = 0; b < 4; b++) begin
                    if (mask_q[idx][b]) begin
                        merged[b*LANE_W +: LANE_W] = data_q[idx][b*LANE_W +: LANE_W];
                    end
                end
`endif
            end
        end
    end

    // Stall, forwarding and drain arbitration; stall never depends on iMemReady
    always_comb begin
        is_load   = iReqValid & ~iReqStore;
        is_store  = iReqValid & iReqStore;
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(DEPTH));
        fwd_valid = 1'b0;
        fwd_data  = '0;
`ifdef STORE_FWD_EN
        load_stall = is_load & match_any & ((covered & iByteMask) != iByteMask);
        if (is_load && match_any && !load_stall) begin
            fwd_valid = 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
                if (iByteMask[b]) begin
                    fwd_data[b*LANE_W +: LANE_W] = merged[b*LANE_W +: LANE_W];
                end
            end
        end
`else
        load_stall = is_load & match_any;
`endif
        stall  = (is_store & full) | load_stall;
        // A stalled load gives the port up so the stores it waits on can drain
        mem_we = ~empty & ~(is_load & ~stall);
        enq    = is_store & ~stall;
        deq    = mem_we & iMemReady;
    end

    // Next-state for pointers, occupancy and the entry written at tail
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        addr_d = addr_q;
        data_d = data_q;
        mask_d = mask_q;
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        if (enq) begin
            tail_d         = tail_q + 1'b1;
            addr_d[tail_q] = req_waddr;
            data_d[tail_q] = iWriteData;
            mask_d[tail_q] = iByteMask;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register with asynchronous clear that discards all queued stores
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign oStall       = stall;
    assign oFwdValid    = fwd_valid;
    assign oFwdData     = fwd_data;
    assign oMemWriteEn  = mem_we;
    assign oMemAddress  = {addr_q[head_q], 2'b00};
    assign oMemData     = data_q[head_q];
    assign oMemByteMask = mask_q[head_q];
    assign oEmpty       = empty;

endmodule

// File: doc/store_buffer.md
# store_buffer

Write buffer between the memory stage and the data memory. It accepts committed stores from the pipeline, queues them in a small FIFO, and drains them to the data memory write port whenever that port is not needed by a load. Loads check the queue: a load whose bytes are all covered by queued stores gets its data forwarded, and a load that only partly overlaps stalls until the overlapping stores have drained. This takes store write latency off the load path and gives the data memory a single registered-order write stream.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width
- DEPTH, 4, buffer entries (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- iClk  in  1  clock, all state updates on rising edge
- iRstN  in  1  asynchronous active-low reset
- iReqValid  in  1  memory-stage request present this cycle
- iReqStore  in  1  1 = store, 0 = load
- iAddress  in  DATA_WIDTH  byte address; word address = iAddress[31:2]
- iByteMask  in  4  bytes written (store) or requested (load), already shifted by byte offset
- iWriteData  in  DATA_WIDTH  store data, already lane-aligned
- oStall  out  1  pipeline must hold the current request
- oFwdValid  out  1  load satisfied from buffer; ignore memory read data
- oFwdData  out  DATA_WIDTH  forwarded word; unmasked lanes 0
- oMemWriteEn  out  1  drain write request to data memory
- oMemAddress  out  DATA_WIDTH  word-aligned drain address
- oMemData  out  DATA_WIDTH  drain data
- oMemByteMask  out  4  drain byte enables
- iMemReady  in  1  memory accepts drain write this cycle
- oEmpty  out  1  no entries queued (used by fence)

## Operation
- Storage: DEPTH entries of {word address[31:2], data, mask}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Enqueue: on iReqValid & iReqStore & ~oStall, write the entry at tail, then tail++ and count++.
- Full stall: a store with count==DEPTH asserts oStall. This holds even if a drain completes in the same cycle; there is no combinational path from iMemReady to oStall.
- Load lookup (combinational) compares the word address against every valid entry. Per byte, the youngest matching entry wins. Covered = OR of the masks of matching entries.
  - No match: oFwdValid=0, oStall=0. The load reads memory.
  - Match with (covered & iByteMask)==iByteMask: oFwdValid=1, oFwdData = merged bytes masked by iByteMask, oStall=0.
  - Match with partial coverage: oStall=1 until no matching entry remains.
- Drain arbitration:
  - oMemWriteEn = ~oEmpty & ~(iReqValid & ~iReqStore & ~oStall). An unstalled load owns the memory port; a stalled load does not, which avoids deadlock.
  - The oMem* outputs show the head entry. With oMemWriteEn & iMemReady: head++ and count--.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Stores never forward to stores. Duplicate addresses are kept as separate entries and drained in order.

## Timing
- Reset (async assert, sync release): head=tail=count=0. oEmpty=1. oStall, oFwdValid, oMemWriteEn=0. oFwdData, oMemAddress, oMemData, oMemByteMask=0.
- Reset mid-operation discards all queued stores; no partial drain completes.
- Store enqueue is visible to a load lookup the cycle after acceptance.
- Forwarding has zero-cycle latency; it is combinational in the same cycle as the load.
- Minimum residency: a store can drain one cycle after enqueue.
- oEmpty is registered-state derived (count==0), with no combinational input dependence.

## Configuration
- STORE_FWD_EN defined: forwarding behaves as described above.
- STORE_FWD_EN undefined:
  - oFwdValid and oFwdData are tied to 0.
  - Any address match stalls the load until no matching entry remains.
  - Byte-merge logic is not built.

## Test plan
- Reset with stores queued: assert iRstN=0 with count=3 → oEmpty=1 and oMemWriteEn=0 immediately; after release, no drain writes appear.
- Fill and wrap, with iMemReady=0:
  - Six stores to 0x100..0x114 → first four accepted and oStall=1 on the fifth.
  - Raise iMemReady → drains 0x100, 0x104, … in order, pointers wrap, and the remaining two are accepted.
- Full forward, with iMemReady=0:
  - SW 0x11223344 @0x200, then SB 0xAA @0x201 (mask 0010).
  - LW @0x200 → oFwdValid=1, oFwdData=0x1122AA44, oStall=0.
- Partial hazard:
  - SB 0x55 @0x300 queued, then LW @0x300 (mask 1111) → oStall=1 and oMemWriteEn=1.
  - After the drain with iMemReady=1 → oStall=0, oFwdValid=0.
- Load/drain arbitration: one queued store plus an unrelated LW @0x400 → oMemWriteEn=0 that cycle; the drain occurs the next idle cycle.
- Macro off: repeat the full-forward case → oStall=1 until both stores drain, oFwdValid stays 0.
